serial_subtractor: RTL and testbench

- Bit-serial, LSB-first N-bit subtractor computing A - B, one bit per clock.
- Per-bit datapath is the team's half-subtractor pair: two half-subtractor stages plus an OR form a full subtractor.
- A registered borrow flip-flop carries the borrow between bit cycles.
- Sits downstream of the combinational half-subtractor cell and consumes its Diff/Borrow outputs; serves area-constrained datapaths that accept WIDTH-cycle latency.

---
 rtl/serial_subtractor_if.sv | 22 ++
 rtl/serial_subtractor.sv | 108 ++++++++++
 tb/tb_serial_subtractor.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle between a requester and the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Borrow;

    modport master (
        output start, A, B,
        input  busy, done, Diff, Borrow
    );

    modport slave (
        input  start, A, B,
        output busy, done, Diff, Borrow
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor bit per clock, WIDTH-cycle latency.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             bin_q;
    logic             borrow_q;
    logic             busy_q;
    logic             done_q;

    logic             a0;
    logic             b0;
    logic             hs1_diff;
    logic             hs1_borrow;
    logic             hs2_diff;
    logic             hs2_borrow;
    logic             bout;
    logic             last_bit;
    logic [WIDTH-1:0] res_d;

    // Full subtractor built from two half-subtractor stages plus an OR of their borrows.
    assign a0         = a_q[0];
    assign b0         = b_q[0];
    assign hs1_diff   = a0 ^ b0;
    assign hs1_borrow = ~a0 & b0;
    assign hs2_diff   = hs1_diff ^ bin_q;
    assign hs2_borrow = ~hs1_diff & bin_q;
    assign bout       = hs1_borrow | hs2_borrow;

    assign res_d    = {hs2_diff, res_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // NOTE: every register below is updated with <= so all of them sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        res_q   <= '0;
                        bin_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    bin_q <= bout;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_bit) begin
                        diff_q   <= res_d;
                        borrow_q <= bout;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.Diff   = diff_q;
    assign bus.Borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor with hand-computed expected results.
module tb_serial_subtractor;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus_if ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // NOTE: inputs are driven and outputs sampled on the falling edge, away from the active edge.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_d, input logic exp_b);
        int         lat;
        int         busy_cycles;
        logic       got_done;
        logic       early;
        logic [7:0] diff0;
        lat         = -1;
        busy_cycles = 0;
        got_done    = 1'b0;
        early       = 1'b0;
        diff0       = bus_if.Diff;
        @(negedge clk);
        bus_if.A     = a;
        bus_if.B     = b;
        bus_if.start = 1'b1;
        for (int cyc = 1; cyc <= 40 && !got_done; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus_if.start = 1'b0;
            if (bus_if.busy) busy_cycles++;
            if (bus_if.done) begin
                got_done = 1'b1;
                lat      = cyc - 1;
            end else if (bus_if.Diff !== diff0) begin
                early = 1'b1;
            end
        end
        if (!got_done) begin
            check({tag, " timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, " latency"}, 32'(lat), 32'd8);
            check({tag, " diff"}, 32'(bus_if.Diff), 32'(exp_d));
            check({tag, " borrow"}, 32'(bus_if.Borrow), 32'(exp_b));
            check({tag, " no partial"}, 32'(early), 32'd0);
            check({tag, " busy cycles"}, 32'(busy_cycles), 32'd9);
        end
        @(negedge clk);
        check({tag, " busy after"}, 32'(bus_if.busy), 32'd0);
        check({tag, " done after"}, 32'(bus_if.done), 32'd0);
    endtask

    initial begin
        int  n_done;
        int  last;
        logic saw_done;

        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.A     = '0;
        bus_if.B     = '0;

        repeat (2) @(negedge clk);
        check("rst busy", 32'(bus_if.busy), 32'd0);
        check("rst done", 32'(bus_if.done), 32'd0);
        check("rst diff", 32'(bus_if.Diff), 32'd0);
        check("rst borrow", 32'(bus_if.Borrow), 32'd0);
        rst_n = 1'b1;

        run_op("5-3", 8'd5, 8'd3, 8'h02, 1'b0);
        run_op("3-5", 8'd3, 8'd5, 8'hFE, 1'b1);
        run_op("00-FF", 8'h00, 8'hFF, 8'h01, 1'b1);
        run_op("AA-AA", 8'hAA, 8'hAA, 8'h00, 1'b0);
        run_op("FF-00", 8'hFF, 8'h00, 8'hFF, 1'b0);

        // Start pulses during SHIFT and during DONE must be ignored; operands change after capture.
        n_done = 0;
        last   = -1;
        @(negedge clk);
        bus_if.A     = 8'd10;
        bus_if.B     = 8'd4;
        bus_if.start = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            bus_if.start = 1'b0;
            if (cyc == 1) begin
                bus_if.A = 8'd1;
                bus_if.B = 8'd2;
            end
            if (cyc == 3) bus_if.start = 1'b1;
            if (bus_if.done) begin
                n_done++;
                last = cyc;
                check("ign diff", 32'(bus_if.Diff), 32'h06);
                check("ign borrow", 32'(bus_if.Borrow), 32'd0);
                bus_if.start = 1'b1;
            end
        end
        bus_if.start = 1'b0;
        check("ign done count", 32'(n_done), 32'd1);
        check("ign done cycle", 32'(last), 32'd9);
        check("ign idle", 32'(bus_if.busy), 32'd0);
        check("ign diff hold", 32'(bus_if.Diff), 32'h06);

        // Held start: 9 busy cycles plus one IDLE cycle between completions.
        n_done = 0;
        last   = -1;
        @(negedge clk);
        bus_if.A     = 8'd7;
        bus_if.B     = 8'd9;
        bus_if.start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (bus_if.done) begin
                check("hold diff", 32'(bus_if.Diff), 32'hFE);
                check("hold borrow", 32'(bus_if.Borrow), 32'd1);
                if (n_done == 0) check("hold first latency", 32'(cyc - 1), 32'd8);
                else             check("hold period", 32'(cyc - last), 32'd10);
                last = cyc;
                n_done++;
            end
        end
        bus_if.start = 1'b0;
        check("hold done count", 32'(n_done), 32'd4);
        repeat (12) @(negedge clk);
        check("hold idle", 32'(bus_if.busy), 32'd0);

        // Reset in the middle of an operation.
        run_op("pre-rst 5-3", 8'd5, 8'd3, 8'h02, 1'b0);
        saw_done = 1'b0;
        @(negedge clk);
        bus_if.A     = 8'd200;
        bus_if.B     = 8'd1;
        bus_if.start = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            bus_if.start = 1'b0;
            if (bus_if.done) saw_done = 1'b1;
        end
        check("mid busy", 32'(bus_if.busy), 32'd1);
        check("mid diff held", 32'(bus_if.Diff), 32'h02);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(bus_if.busy), 32'd0);
        check("abort done", 32'(bus_if.done), 32'd0);
        check("abort diff", 32'(bus_if.Diff), 32'd0);
        check("abort borrow", 32'(bus_if.Borrow), 32'd0);
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            if (bus_if.done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (bus_if.done || bus_if.busy) saw_done = 1'b1;
        end
        check("abort no done", 32'(saw_done), 32'd0);
        run_op("9-9", 8'd9, 8'd9, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
